pic_ack_sequencer: RTL and testbench

Clocked control block of the 8259A PIC that runs the two-pulse 8086-mode INTA cycle, selects the serviced level, maintains ISR and the rotating-priority pointer, and executes OCW2 EOI/rotation commands. It sits between the IRR/IMR registers, the OCW2 write path and the data-bus driver. It produces the level-selection result, the interrupt output and the vector byte.

---
 rtl/pic_ack_if.sv | 25 ++
 rtl/pic_ack_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pic_ack_if.sv
// Bus bundle between the 8259A acknowledge sequencer and its surroundings
// (IRR/IMR/ICW2 sources, OCW2 write path, CPU interrupt line and data-bus driver).
interface pic_ack_if;
  logic [7:0] IRR;
  logic [7:0] IMR;
  logic       INTA;
  logic [7:0] ICW2;
  logic [7:0] OCW2;
  logic       OCW2_WR;
  logic       INT;
  logic [7:0] ISR;
  logic [7:0] IRR_CLR;
  logic [7:0] DOUT;
  logic       DOUT_EN;

  modport slave (
    input  IRR, IMR, INTA, ICW2, OCW2, OCW2_WR,
    output INT, ISR, IRR_CLR, DOUT, DOUT_EN
  );

  modport master (
    output IRR, IMR, INTA, ICW2, OCW2, OCW2_WR,
    input  INT, ISR, IRR_CLR, DOUT, DOUT_EN
  );
endinterface

// File: rtl/pic_ack_sequencer.sv
// 8259A 8086-mode two-pulse INTA sequencer with ISR, priority pointer and OCW2 EOI handling.
// Optional feature macro PIC_ROTATE_EN enables a writable lowest-priority pointer (rotation).
module pic_ack_sequencer (
  input  logic        clk,
  input  logic        reset,
  pic_ack_if.slave    bus
);

  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_inta_d;
  logic [7:0] r_isr;
  logic [7:0] r_irr_clr;
  logic [7:0] r_dout;
  logic       r_dout_en;
  logic       r_int;
  logic [2:0] r_lvl;

  logic [2:0] w_lp;
  logic       w_fall;
  logic       w_rise;
  logic [7:0] w_req;
  logic [3:0] w_req_pick;
  logic [3:0] w_isr_pick;
  logic       w_eligible;
  logic [7:0] w_isr_set;
  logic [7:0] w_isr_clr;
  logic [2:0] w_lvl_next;
  logic       w_dout_load;
  logic       w_dout_clr;

  // {found, level} of the highest-priority set bit; priority starts at lp+1 and descends.
  function automatic logic [3:0] prio_pick(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = lp + 3'd1 + 3'(i);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // 0 = highest priority position on the ring.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

`ifdef PIC_ROTATE_EN
  logic [2:0] r_lp;
  logic       w_lp_load;
  logic [2:0] w_lp_val;
  assign w_lp = r_lp;
`else
  assign w_lp = 3'd7;
`endif

  assign w_fall     = r_inta_d & ~bus.INTA;
  assign w_rise     = ~r_inta_d & bus.INTA;
  assign w_req      = bus.IRR & ~bus.IMR;
  assign w_req_pick = prio_pick(w_req, w_lp);
  assign w_isr_pick = prio_pick(r_isr, w_lp);
  assign w_eligible = w_req_pick[3] &&
                      (!w_isr_pick[3] ||
                       (prio_rank(w_req_pick[2:0], w_lp) < prio_rank(w_isr_pick[2:0], w_lp)));

  always_comb begin
    w_isr_clr = '0;
`ifdef PIC_ROTATE_EN
    w_lp_load = 1'b0;
    w_lp_val  = r_lp;
`endif
    if (bus.OCW2_WR) begin
      case (bus.OCW2[7:5])
        3'b001: if (w_isr_pick[3]) w_isr_clr = onehot(w_isr_pick[2:0]);
        3'b011: w_isr_clr = onehot(bus.OCW2[2:0]);
`ifdef PIC_ROTATE_EN
        3'b101: if (w_isr_pick[3]) begin
          w_isr_clr = onehot(w_isr_pick[2:0]);
          w_lp_load = 1'b1;
          w_lp_val  = w_isr_pick[2:0];
        end
        3'b111: begin
          w_isr_clr = onehot(bus.OCW2[2:0]);
          w_lp_load = 1'b1;
          w_lp_val  = bus.OCW2[2:0];
        end
        3'b110: begin
          w_lp_load = 1'b1;
          w_lp_val  = bus.OCW2[2:0];
        end
`else
        3'b101: if (w_isr_pick[3]) w_isr_clr = onehot(w_isr_pick[2:0]);
        3'b111: w_isr_clr = onehot(bus.OCW2[2:0]);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_isr_set    = '0;
    w_lvl_next   = r_lvl;
    w_dout_load  = 1'b0;
    w_dout_clr   = 1'b0;
    case (r_state)
      IDLE: if (w_fall) begin
        w_state_next = ACK1;
        if (w_eligible) begin
          w_lvl_next = w_req_pick[2:0];
          w_isr_set  = onehot(w_req_pick[2:0]);
        end else begin
          w_lvl_next = SPURIOUS_LEVEL;
        end
      end
      ACK1:  if (w_rise) w_state_next = WAIT2;
      WAIT2: if (w_fall) begin
        w_state_next = ACK2;
        w_dout_load  = 1'b1;
      end
      ACK2:  if (w_rise) begin
        w_state_next = IDLE;
        w_dout_clr   = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // INTA history follows the pin even in reset so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    r_inta_d <= bus.INTA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_isr     <= '0;
      r_irr_clr <= '0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
      r_int     <= 1'b0;
      r_lvl     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_isr     <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_irr_clr <= w_isr_set;
      r_lvl     <= w_lvl_next;
      r_int     <= (w_state_next == IDLE) && w_eligible;
      if (w_dout_load) begin
        r_dout    <= {bus.ICW2[7:3], r_lvl};
        r_dout_en <= 1'b1;
      end else if (w_dout_clr) begin
        r_dout    <= '0;
        r_dout_en <= 1'b0;
      end
    end
  end

`ifdef PIC_ROTATE_EN
  always_ff @(posedge clk) begin
    if (reset)          r_lp <= 3'd7;
    else if (w_lp_load) r_lp <= w_lp_val;
  end
`endif

  assign bus.INT     = r_int;
  assign bus.ISR     = r_isr;
  assign bus.IRR_CLR = r_irr_clr;
  assign bus.DOUT    = r_dout;
  assign bus.DOUT_EN = r_dout_en;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench for pic_ack_sequencer: reset, fixed-priority ack, nesting/masking,
// EOI commands, spurious acknowledge, set/clear collision, rotation and mid-sequence reset.
module tb_pic_ack_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  pic_ack_if bus_if ();

  pic_ack_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

`ifdef PIC_ROTATE_EN
  localparam logic [7:0] ROT_ISR  = 8'h80;
  localparam logic [7:0] ROT_DOUT = 8'h47;
`else
  localparam logic [7:0] ROT_ISR  = 8'h01;
  localparam logic [7:0] ROT_DOUT = 8'h40;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic ocw2(input logic [7:0] cmd);
    bus_if.OCW2    = cmd;
    bus_if.OCW2_WR = 1'b1;
    tick();
    bus_if.OCW2_WR = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.IRR     = 8'h00;
    bus_if.IMR     = 8'h00;
    bus_if.INTA    = 1'b1;
    bus_if.ICW2    = 8'h40;
    bus_if.OCW2    = 8'h00;
    bus_if.OCW2_WR = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_int", {7'd0, bus_if.INT}, 8'h00);
    chk("rst_isr", bus_if.ISR, 8'h00);
    chk("rst_irr_clr", bus_if.IRR_CLR, 8'h00);
    chk("rst_dout", bus_if.DOUT, 8'h00);
    chk("rst_dout_en", {7'd0, bus_if.DOUT_EN}, 8'h00);

    // Fixed-priority acknowledge of IR3 out of 0x28
    bus_if.IRR = 8'h28;
    tick();
    chk("fix_int", {7'd0, bus_if.INT}, 8'h01);
    bus_if.INTA = 1'b0;
    tick();
    chk("fix_isr", bus_if.ISR, 8'h08);
    chk("fix_irr_clr", bus_if.IRR_CLR, 8'h08);
    chk("fix_int_low", {7'd0, bus_if.INT}, 8'h00);
    bus_if.IRR = 8'h20;
    tick();
    chk("fix_irr_clr_pulse", bus_if.IRR_CLR, 8'h00);
    bus_if.INTA = 1'b1;
    tick();
    chk("fix_dout_en_wait2", {7'd0, bus_if.DOUT_EN}, 8'h00);
    bus_if.INTA = 1'b0;
    tick();
    chk("fix_dout", bus_if.DOUT, 8'h43);
    chk("fix_dout_en", {7'd0, bus_if.DOUT_EN}, 8'h01);
    tick();
    chk("fix_dout_hold", bus_if.DOUT, 8'h43);
    bus_if.INTA = 1'b1;
    tick();
    chk("fix_dout_off", bus_if.DOUT, 8'h00);
    chk("fix_dout_en_off", {7'd0, bus_if.DOUT_EN}, 8'h00);
    chk("nest_lower_int", {7'd0, bus_if.INT}, 8'h00);

    // Nesting and masking with ISR=0x08
    bus_if.IRR = 8'h02;
    bus_if.IMR = 8'h02;
    tick();
    chk("mask_int", {7'd0, bus_if.INT}, 8'h00);
    bus_if.IMR = 8'h00;
    tick();
    chk("unmask_int", {7'd0, bus_if.INT}, 8'h01);
    bus_if.INTA = 1'b0;
    tick();
    chk("nest_isr", bus_if.ISR, 8'h0A);
    chk("nest_irr_clr", bus_if.IRR_CLR, 8'h02);
    bus_if.IRR  = 8'h00;
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("nest_dout", bus_if.DOUT, 8'h41);
    bus_if.INTA = 1'b1;
    tick();

    // EOI commands
    ocw2(8'h20);
    chk("eoi_ns", bus_if.ISR, 8'h08);
    ocw2(8'h63);
    chk("eoi_sp", bus_if.ISR, 8'h00);
    ocw2(8'h20);
    chk("eoi_ns_empty", bus_if.ISR, 8'h00);

    // Spurious acknowledge
    bus_if.INTA = 1'b0;
    tick();
    chk("spur_isr", bus_if.ISR, 8'h00);
    chk("spur_irr_clr", bus_if.IRR_CLR, 8'h00);
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("spur_dout", bus_if.DOUT, 8'h47);
    bus_if.INTA = 1'b1;
    tick();

    // Specific EOI on IR2 in the same cycle the acknowledge sets ISR[2]
    bus_if.IRR = 8'h04;
    tick();
    chk("coll_int", {7'd0, bus_if.INT}, 8'h01);
    bus_if.INTA    = 1'b0;
    bus_if.OCW2    = 8'h62;
    bus_if.OCW2_WR = 1'b1;
    tick();
    bus_if.OCW2_WR = 1'b0;
    chk("coll_isr", bus_if.ISR, 8'h04);
    chk("coll_irr_clr", bus_if.IRR_CLR, 8'h04);
    bus_if.IRR  = 8'h00;
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("coll_dout", bus_if.DOUT, 8'h42);
    bus_if.INTA = 1'b1;
    tick();
    ocw2(8'h62);
    chk("coll_eoi", bus_if.ISR, 8'h00);

    // Rotation: serve IR0, rotate on non-specific EOI, then IRR=0x81
    bus_if.IRR  = 8'h01;
    bus_if.INTA = 1'b0;
    tick();
    chk("rot_isr0", bus_if.ISR, 8'h01);
    bus_if.IRR  = 8'h00;
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    bus_if.INTA = 1'b1;
    tick();
    ocw2(8'hA0);
    chk("rot_eoi", bus_if.ISR, 8'h00);
    bus_if.IRR  = 8'h81;
    bus_if.INTA = 1'b0;
    tick();
    chk("rot_isr", bus_if.ISR, ROT_ISR);
    bus_if.IRR  = 8'h00;
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("rot_dout", bus_if.DOUT, ROT_DOUT);
    bus_if.INTA = 1'b1;
    tick();

    // Reset in the middle of ACK2
    bus_if.INTA = 1'b0;
    tick();
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("mid_dout_en", {7'd0, bus_if.DOUT_EN}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_dout_en", {7'd0, bus_if.DOUT_EN}, 8'h00);
    chk("mid_rst_dout", bus_if.DOUT, 8'h00);
    chk("mid_rst_isr", bus_if.ISR, 8'h00);
    chk("mid_rst_int", {7'd0, bus_if.INT}, 8'h00);
    bus_if.INTA = 1'b1;
    tick();
    bus_if.IRR = 8'h81;
    tick();
    chk("post_rst_int", {7'd0, bus_if.INT}, 8'h01);
    bus_if.INTA = 1'b0;
    tick();
    chk("post_rst_isr", bus_if.ISR, 8'h01);
    chk("post_rst_irr_clr", bus_if.IRR_CLR, 8'h01);
    bus_if.IRR  = 8'h80;
    bus_if.INTA = 1'b1;
    tick();
    bus_if.INTA = 1'b0;
    tick();
    chk("post_rst_dout", bus_if.DOUT, 8'h40);
    bus_if.INTA = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
